clock_pattern_detector: RTL and testbench

- Receiver-side counterpart of the mainband clock-training transmitter.
- The far end sends repeated iterations of 16 clock cycles followed by 8 gated (idle) cycles on RCKP, RCKN and RTRACK.
- The analog front end delivers one pulse-present bit per lane per i_local_ckp cycle. This block checks the burst/gap structure per lane, counts valid iterations, and reports pass/fail per lane to the MBINIT clock-test logic.

---
 rtl/clock_pattern_detector.sv | 230 +++++++++++++++++++++++
 tb/tb_clock_pattern_detector.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_pattern_detector.sv
`default_nettype none
// ============================================================================
// Module      : clock_pattern_detector
// Description : Receiver-side checker for the mainband clock-training pattern.
//               Validates the burst/gap structure on RCKP, RCKN and RTRACK,
//               counts valid iterations per lane within a bounded window and
//               reports per-lane pass/fail to the MBINIT clock-test logic.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_pattern_detector #(
    parameter int BURST_LEN      = 16,
    parameter int GAP_LEN        = 8,
    parameter int ITERATIONS     = 128,
    parameter int PASS_THRESHOLD = 16,
    parameter int TIMEOUT        = 3136
) (
    input  logic       i_local_ckp,
    input  logic       i_rst,
    input  logic       i_start_clk_detect,
    input  logic       i_ckp_pulse,
    input  logic       i_ckn_pulse,
    input  logic       i_track_pulse,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_ckp_pass,
    output logic       o_ckn_pass,
    output logic       o_track_pass,
    output logic [7:0] o_ckp_cnt,
    output logic [7:0] o_ckn_cnt,
    output logic [7:0] o_track_cnt
);

    localparam int c_LANES = 3;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_DETECT = 2'd1;
    localparam logic [1:0] c_ST_DONE   = 2'd2;

    localparam logic [11:0] c_WIN_LAST = 12'(TIMEOUT - 1);
    localparam logic [7:0]  c_CNT_MAX  = 8'(ITERATIONS);
    localparam logic [7:0]  c_PASS_MIN = 8'(PASS_THRESHOLD);
    localparam logic [4:0]  c_BURST    = 5'(BURST_LEN);
    localparam logic [3:0]  c_GAP      = 4'(GAP_LEN);
    localparam logic [4:0]  c_ONE_SAT  = 5'd31;
    localparam logic [3:0]  c_ZERO_SAT = 4'd15;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_start_d;
    logic        r_start_low_seen;
    logic [11:0] r_win;

    logic        w_rise;
    logic        w_fall;
    logic        w_run;
    logic        w_enter;
    logic        w_abort;
    logic        w_finish;
    logic        w_win_end;
    logic        w_all_full;

    logic        w_pulse   [c_LANES];
    logic [7:0]  w_cnt     [c_LANES];
    logic [7:0]  w_cnt_nxt [c_LANES];
    logic        w_pass    [c_LANES];

    assign w_pulse[0] = i_ckp_pulse;
    assign w_pulse[1] = i_ckn_pulse;
    assign w_pulse[2] = i_track_pulse;

    // A start held high through reset must fall once before it can arm again,
    // so the rise is only honoured after start has been seen low.
    assign w_rise = i_start_clk_detect & ~r_start_d & r_start_low_seen;
    assign w_fall = ~i_start_clk_detect & r_start_d;

    assign w_run      = (r_state == c_ST_DETECT);
    assign w_win_end  = (r_win == c_WIN_LAST);
    assign w_all_full = (w_cnt_nxt[0] == c_CNT_MAX) &&
                        (w_cnt_nxt[1] == c_CNT_MAX) &&
                        (w_cnt_nxt[2] == c_CNT_MAX);

    assign w_enter  = (w_state_nxt == c_ST_DETECT) && (r_state != c_ST_DETECT);
    assign w_abort  = w_run && (w_state_nxt == c_ST_IDLE);
    assign w_finish = w_run && (w_state_nxt == c_ST_DONE);

    // Start edge-detect history
    always_ff @(posedge i_local_ckp) begin
        if (i_rst) begin
            r_start_d        <= 1'b0;
            r_start_low_seen <= 1'b0;
        end else begin
            r_start_d <= i_start_clk_detect;
            if (!i_start_clk_detect) begin
                r_start_low_seen <= 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge i_local_ckp) begin
        if (i_rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; abort takes priority over window end
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = c_ST_DETECT;
                end
            end
            c_ST_DETECT: begin
                if (w_fall) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (w_win_end || w_all_full) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                if (w_rise) begin
                    w_state_nxt = c_ST_DETECT;
                end else if (w_fall) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // FSM outputs decoded from the state register
    always_comb begin
        o_busy = (r_state == c_ST_DETECT);
        o_done = (r_state == c_ST_DONE);
    end

    // Detection window counter; stops at its last value so it never wraps
    always_ff @(posedge i_local_ckp) begin
        if (i_rst || w_enter) begin
            r_win <= '0;
        end else if (w_run && !w_win_end) begin
            r_win <= r_win + 12'd1;
        end
    end

    for (genvar g = 0; g < c_LANES; g++) begin : g_lane
        logic       r_prev;
        logic [4:0] r_one;
        logic [3:0] r_zero;
        logic       r_ok;
        logic [7:0] r_cnt;
        logic       r_pass;

        logic [4:0] w_one_nxt;
        logic [3:0] w_zero_nxt;
        logic       w_ok_nxt;
        logic       w_hit;
        logic [7:0] w_cnt_l;

        // Run-length tracking and iteration qualification for this lane
        always_comb begin
            w_one_nxt  = r_one;
            w_zero_nxt = r_zero;
            w_ok_nxt   = r_ok;
            if (w_pulse[g]) begin
                w_zero_nxt = 4'd0;
                if (!r_prev) begin
                    w_one_nxt = 5'd1;
                    w_ok_nxt  = 1'b0;
                end else if (r_one != c_ONE_SAT) begin
                    w_one_nxt = r_one + 5'd1;
                end
            end else begin
                if (r_prev) begin
                    w_ok_nxt   = (r_one == c_BURST);
                    w_zero_nxt = 4'd1;
                end else if (r_zero != c_ZERO_SAT) begin
                    w_zero_nxt = r_zero + 4'd1;
                end
            end
            // Count once, at the moment the gap reaches its full length
            w_hit   = !w_pulse[g] && w_ok_nxt &&
                      (w_zero_nxt == c_GAP) && (r_zero != c_GAP);
            w_cnt_l = r_cnt;
            if (w_run && w_hit && (r_cnt != c_CNT_MAX)) begin
                w_cnt_l = r_cnt + 8'd1;
            end
        end

        // Lane state: cleared on arm/abort, updated only while detecting
        always_ff @(posedge i_local_ckp) begin
            if (i_rst || w_enter || w_abort) begin
                r_prev <= 1'b0;
                r_one  <= '0;
                r_zero <= '0;
                r_ok   <= 1'b0;
                r_cnt  <= '0;
                r_pass <= 1'b0;
            end else if (w_run) begin
                r_prev <= w_pulse[g];
                r_one  <= w_one_nxt;
                r_zero <= w_zero_nxt;
                r_ok   <= w_ok_nxt;
                r_cnt  <= w_cnt_l;
                if (w_finish) begin
                    r_pass <= (w_cnt_l >= c_PASS_MIN);
                end
            end
        end

        assign w_cnt[g]     = r_cnt;
        assign w_cnt_nxt[g] = w_cnt_l;
        assign w_pass[g]    = r_pass;
    end

    assign o_ckp_cnt    = w_cnt[0];
    assign o_ckn_cnt    = w_cnt[1];
    assign o_track_cnt  = w_cnt[2];
    assign o_ckp_pass   = w_pass[0];
    assign o_ckn_pass   = w_pass[1];
    assign o_track_pass = w_pass[2];

endmodule
`default_nettype wire

// File: tb/tb_clock_pattern_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_pattern_detector
// Description : Directed self-checking bench for clock_pattern_detector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_pattern_detector;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_start_clk_detect = 1'b0;
    logic       i_ckp_pulse = 1'b0;
    logic       i_ckn_pulse = 1'b0;
    logic       i_track_pulse = 1'b0;
    logic       o_busy;
    logic       o_done;
    logic       o_ckp_pass;
    logic       o_ckn_pass;
    logic       o_track_pass;
    logic [7:0] o_ckp_cnt;
    logic [7:0] o_ckn_cnt;
    logic [7:0] o_track_cnt;

    int total = 0;
    int bad   = 0;

    logic [4:0]  st;
    logic [23:0] cn;

    always #5 clk = ~clk;

    clock_pattern_detector dut (
        .i_local_ckp        (clk),
        .i_rst              (i_rst),
        .i_start_clk_detect (i_start_clk_detect),
        .i_ckp_pulse        (i_ckp_pulse),
        .i_ckn_pulse        (i_ckn_pulse),
        .i_track_pulse      (i_track_pulse),
        .o_busy             (o_busy),
        .o_done             (o_done),
        .o_ckp_pass         (o_ckp_pass),
        .o_ckn_pass         (o_ckn_pass),
        .o_track_pass       (o_track_pass),
        .o_ckp_cnt          (o_ckp_cnt),
        .o_ckn_cnt          (o_ckn_cnt),
        .o_track_cnt        (o_track_cnt)
    );

    // status = {busy, done, ckp_pass, ckn_pass, track_pass}
    always_comb st = {o_busy, o_done, o_ckp_pass, o_ckn_pass, o_track_pass};
    always_comb cn = {o_ckp_cnt, o_ckn_cnt, o_track_cnt};

    // Each iteration is 24 samples; a lane emits ones for the first len samples.
    task automatic run_iters(input int n, input int lp, input int ln, input int lt);
        for (int it = 0; it < n; it++) begin
            for (int c = 0; c < 24; c++) begin
                i_ckp_pulse   = (c < lp);
                i_ckn_pulse   = (c < ln);
                i_track_pulse = (c < lt);
                @(negedge clk);
            end
        end
        i_ckp_pulse   = 1'b0;
        i_ckn_pulse   = 1'b0;
        i_track_pulse = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    // Rise of start sampled on the first edge, one quiet cycle after it
    task automatic arm();
        i_start_clk_detect = 1'b1;
        idle(2);
    endtask

    task automatic disarm();
        i_start_clk_detect = 1'b0;
        idle(1);
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        idle(3);
        i_rst = 1'b0;
        idle(2);
        total++;
        if (st !== 5'b00000) begin
            bad++; $display("FAIL reset_status got=%b want=%b", st, 5'b00000);
        end
        total++;
        if (cn !== 24'h000000) begin
            bad++; $display("FAIL reset_counts got=%h want=%h", cn, 24'h000000);
        end
    endtask

    task automatic test_clean();
        arm();
        total++;
        if (st !== 5'b10000) begin
            bad++; $display("FAIL clean_armed got=%b want=%b", st, 5'b10000);
        end
        run_iters(10, 16, 16, 16);
        total++;
        if (cn !== {8'd10, 8'd10, 8'd10}) begin
            bad++; $display("FAIL clean_live_cnt got=%h want=%h", cn, {8'd10, 8'd10, 8'd10});
        end
        run_iters(118, 16, 16, 16);
        idle(2);
        total++;
        if (st !== 5'b01111) begin
            bad++; $display("FAIL clean_done got=%b want=%b", st, 5'b01111);
        end
        total++;
        if (cn !== {8'd128, 8'd128, 8'd128}) begin
            bad++; $display("FAIL clean_cnt got=%h want=%h", cn, {8'd128, 8'd128, 8'd128});
        end
        disarm();
        total++;
        if (st !== 5'b00111) begin
            bad++; $display("FAIL done_drop got=%b want=%b", st, 5'b00111);
        end
        total++;
        if (cn !== {8'd128, 8'd128, 8'd128}) begin
            bad++; $display("FAIL done_drop_cnt got=%h want=%h", cn, {8'd128, 8'd128, 8'd128});
        end
    endtask

    task automatic test_ckn_stuck();
        arm();
        total++;
        if (st !== 5'b10000) begin
            bad++; $display("FAIL ckn_arm_clears_pass got=%b want=%b", st, 5'b10000);
        end
        run_iters(128, 16, 0, 16);
        idle(62);
        total++;
        if (st !== 5'b10000) begin
            bad++; $display("FAIL ckn_before_timeout got=%b want=%b", st, 5'b10000);
        end
        idle(1);
        total++;
        if (st !== 5'b01101) begin
            bad++; $display("FAIL ckn_timeout got=%b want=%b", st, 5'b01101);
        end
        total++;
        if (cn !== {8'd128, 8'd0, 8'd128}) begin
            bad++; $display("FAIL ckn_cnt got=%h want=%h", cn, {8'd128, 8'd0, 8'd128});
        end
        disarm();
    endtask

    task automatic test_track_threshold(input int good, input logic exp_pass);
        int waited;
        arm();
        run_iters(128 - good, 16, 16, 15);
        run_iters(good, 16, 16, 16);
        waited = 0;
        while (!o_done && waited < 200) begin
            idle(1);
            waited++;
        end
        total++;
        if (o_done !== 1'b1) begin
            bad++; $display("FAIL track_wait_done got=%b want=1 after %0d cycles", o_done, waited);
        end
        total++;
        if (st !== {2'b01, 2'b11, exp_pass}) begin
            bad++; $display("FAIL track_pass_%0d got=%b want=%b", good, st, {2'b01, 2'b11, exp_pass});
        end
        total++;
        if (cn !== {8'd128, 8'd128, 8'(good)}) begin
            bad++; $display("FAIL track_cnt_%0d got=%h want=%h", good, cn, {8'd128, 8'd128, 8'(good)});
        end
        disarm();
    endtask

    task automatic test_abort();
        arm();
        run_iters(50, 16, 16, 16);
        total++;
        if (cn !== {8'd50, 8'd50, 8'd50}) begin
            bad++; $display("FAIL abort_pre_cnt got=%h want=%h", cn, {8'd50, 8'd50, 8'd50});
        end
        disarm();
        total++;
        if (st !== 5'b00000) begin
            bad++; $display("FAIL abort_status got=%b want=%b", st, 5'b00000);
        end
        total++;
        if (cn !== 24'h000000) begin
            bad++; $display("FAIL abort_cnt got=%h want=%h", cn, 24'h000000);
        end
        arm();
        run_iters(5, 16, 16, 16);
        total++;
        if (cn !== {8'd5, 8'd5, 8'd5}) begin
            bad++; $display("FAIL abort_restart_cnt got=%h want=%h", cn, {8'd5, 8'd5, 8'd5});
        end
        disarm();
    endtask

    task automatic test_reset_mid();
        arm();
        run_iters(70, 16, 16, 16);
        total++;
        if (cn !== {8'd70, 8'd70, 8'd70}) begin
            bad++; $display("FAIL rstmid_pre_cnt got=%h want=%h", cn, {8'd70, 8'd70, 8'd70});
        end
        i_rst = 1'b1;
        idle(1);
        total++;
        if ({st, cn} !== 29'd0) begin
            bad++; $display("FAIL rstmid_outputs got=%h want=%h", {st, cn}, 29'd0);
        end
        i_rst = 1'b0;
        run_iters(3, 16, 16, 16);
        total++;
        if ({st, cn} !== 29'd0) begin
            bad++; $display("FAIL rstmid_no_rearm got=%h want=%h", {st, cn}, 29'd0);
        end
        disarm();
        arm();
        run_iters(3, 16, 16, 16);
        total++;
        if ({st, cn} !== {5'b10000, 8'd3, 8'd3, 8'd3}) begin
            bad++; $display("FAIL rstmid_rearm got=%h want=%h", {st, cn}, {5'b10000, 8'd3, 8'd3, 8'd3});
        end
        disarm();
    endtask

    task automatic test_short_gap();
        // 16 ones + 7 zeros then a fresh burst: the short gap must not count
        arm();
        for (int c = 0; c < 23; c++) begin
            i_ckp_pulse   = (c < 16);
            i_ckn_pulse   = (c < 16);
            i_track_pulse = (c < 16);
            @(negedge clk);
        end
        run_iters(2, 16, 16, 16);
        total++;
        if (cn !== {8'd2, 8'd2, 8'd2}) begin
            bad++; $display("FAIL short_gap_cnt got=%h want=%h", cn, {8'd2, 8'd2, 8'd2});
        end
        disarm();
    endtask

    initial begin
        test_reset();
        test_clean();
        test_ckn_stuck();
        test_track_threshold(8, 1'b0);
        test_track_threshold(16, 1'b1);
        test_abort();
        test_reset_mid();
        test_short_gap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
